mtm_alu_cmd_serializer: RTL

MTM_ALU_CMD_SERIALIZER -- requirements
Module: mtm_alu_cmd_serializer

---
 rtl/mtm_alu_cmd_serializer_pkg.sv | 43 ++++
 rtl/mtm_alu_cmd_serializer_if.sv | 33 +++
 rtl/mtm_alu_cmd_serializer_frame_tx.sv | 58 +++++
 rtl/mtm_alu_cmd_serializer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mtm_alu_cmd_serializer_pkg.sv
// ---------------------------------------------------------------------------
// mtm_alu_pkg
// Shared types, frame constants and the CRC-4 helper for the MTM ALU command
// serializer. Imported by the interface, the frame transmitter and the top.
//   op_t        : ALU operation encoding
//   state_t     : sequencing FSM states of the serializer
//   crc4_calc() : CRC-4 (x^4+x+1, init 0, MSB first, no reflection/final XOR)
// ---------------------------------------------------------------------------
package mtm_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CMD  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [3:0] FRAME_LEN = 4'd11;
    localparam logic [3:0] N_DATA    = 4'd8;
    localparam logic       TYPE_DATA = 1'b0;
    localparam logic       TYPE_CMD  = 1'b1;
    localparam logic [2:0] BAD_OP    = 3'b010;

    // Bit-serial CRC-4 over the 68-bit message {B, A, 1'b1, op}, MSB first.
    function automatic logic [3:0] crc4_calc(input logic [67:0] data);
        logic [3:0] crc;
        logic       fb;
        crc = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb  = crc[3] ^ data[i];
            crc = {crc[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return crc;
    endfunction

endpackage

// File: rtl/mtm_alu_cmd_serializer_if.sv
// ---------------------------------------------------------------------------
// mtm_alu_cmd_serializer_if
// Command handshake plus serial output bundle of the serializer.
//   cmd_valid / cmd_ready : command handshake
//   B, A, op, err_flags   : command contents (err_flags: [0] data-count,
//                           [1] CRC, [2] op)
//   sin                   : serial stream to the ALU, idle high
//   busy                  : frame transmission in progress
// master modport = command source, slave modport = serializer.
// ---------------------------------------------------------------------------
interface mtm_alu_cmd_serializer_if;
    import mtm_alu_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] B;
    logic [31:0] A;
    op_t         op;
    logic [2:0]  err_flags;
    logic        sin;
    logic        busy;

    modport master (
        output cmd_valid, B, A, op, err_flags,
        input  cmd_ready, sin, busy
    );

    modport slave (
        input  cmd_valid, B, A, op, err_flags,
        output cmd_ready, sin, busy
    );

endinterface

// File: rtl/mtm_alu_cmd_serializer_frame_tx.sv
// ---------------------------------------------------------------------------
// mtm_alu_frame_tx
// Loads {type, payload} and shifts out one 11-bit frame
// (start 0, type, payload[7:0] MSB first, stop 1), one bit per clock.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : capture a new frame; its start bit appears on the next cycle
//   frame_type   : 0 data / 1 cmd
//   payload      : 8-bit frame payload
//   sin          : serial output, straight from the shift-register MSB flop
//   done         : high during the stop-bit cycle, so a new load lands
//                  back-to-back with no idle bit in between
// ---------------------------------------------------------------------------
module mtm_alu_frame_tx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       frame_type,
    input  logic [7:0] payload,
    output logic       sin,
    output logic       done
);

    localparam logic [3:0] LAST_BIT = FRAME_LEN - 4'd1;

    logic [10:0] shreg_r;
    logic [3:0]  bit_cnt_r;
    logic        active_r;

    // Frame shift register and bit counter; ones are shifted in so the line idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r   <= 11'h7FF;
            bit_cnt_r <= 4'd0;
            active_r  <= 1'b0;
        end else if (load) begin
            shreg_r   <= {1'b0, frame_type, payload, 1'b1};
            bit_cnt_r <= 4'd0;
            active_r  <= 1'b1;
        end else if (active_r) begin
            shreg_r <= {shreg_r[9:0], 1'b1};
            if (bit_cnt_r == LAST_BIT) begin
                bit_cnt_r <= 4'd0;
                active_r  <= 1'b0;
            end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end
        end else begin
            shreg_r   <= 11'h7FF;
            bit_cnt_r <= 4'd0;
        end
    end

    assign sin  = shreg_r[10];
    assign done = active_r && (bit_cnt_r == LAST_BIT);

endmodule

// File: rtl/mtm_alu_cmd_serializer.sv
// ---------------------------------------------------------------------------
// mtm_alu_cmd_serializer
// Serializes one ALU command as 8 data frames (B then A, MSB byte first) and
// one cmd frame {0, op, crc4}, followed by a 2-cycle high gap.
//   clk, rst_n : clock, asynchronous active-low reset (aborts a frame at once)
//   bus        : slave side of mtm_alu_cmd_serializer_if
//                (cmd_valid/cmd_ready handshake, B, A, op, err_flags, sin, busy)
// err_flags[0] drops the A[7:0] frame, [1] inverts the sent CRC,
// [2] substitutes BAD_OP for op (the CRC covers the substituted op).
// ---------------------------------------------------------------------------
module mtm_alu_cmd_serializer
    import mtm_alu_pkg::*;
(
    input logic                    clk,
    input logic                    rst_n,
    mtm_alu_cmd_serializer_if.slave bus
);

    localparam logic [2:0] LAST_FULL  = 3'(N_DATA - 4'd1);
    localparam logic [2:0] LAST_SHORT = 3'(N_DATA - 4'd2);

    state_t      state_r, state_s;
    logic [2:0]  frame_cnt_r, frame_cnt_s;
    logic        gap_cnt_r, gap_cnt_s;
    logic        cmd_ready_r, ready_s;
    logic        busy_r, busy_s;
    logic [63:0] data_r;
    logic [7:0]  cmd_payload_r;
    logic        omit_r;

    logic        accept_s;
    logic [2:0]  eff_op_s;
    logic [3:0]  crc_s;
    logic [2:0]  last_data_s;
    logic        tx_load_s;
    logic        tx_type_s;
    logic [7:0]  tx_payload_s;
    logic        tx_done_s;
    logic        tx_sin_s;

    assign accept_s    = bus.cmd_valid & cmd_ready_r;
    assign eff_op_s    = bus.err_flags[2] ? BAD_OP : 3'(bus.op);
    assign crc_s       = crc4_calc({bus.B, bus.A, 1'b1, eff_op_s}) ^ {4{bus.err_flags[1]}};
    assign last_data_s = omit_r ? LAST_SHORT : LAST_FULL;

    mtm_alu_frame_tx u_frame_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tx_load_s),
        .frame_type (tx_type_s),
        .payload    (tx_payload_s),
        .sin        (tx_sin_s),
        .done       (tx_done_s)
    );

    // Next-state, frame loading and registered-output targets of the sequencer.
    always_comb begin
        state_s      = state_r;
        frame_cnt_s  = frame_cnt_r;
        gap_cnt_s    = gap_cnt_r;
        tx_load_s    = 1'b0;
        tx_type_s    = TYPE_DATA;
        tx_payload_s = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s      = ST_DATA;
                    frame_cnt_s  = 3'd0;
                    tx_load_s    = 1'b1;
                    tx_payload_s = bus.B[31:24];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (tx_done_s) begin
                    tx_load_s = 1'b1;
                    if (frame_cnt_r == last_data_s) begin
                        state_s      = ST_CMD;
                        frame_cnt_s  = 3'd0;
                        tx_type_s    = TYPE_CMD;
                        tx_payload_s = cmd_payload_r;
                    end else begin
                        frame_cnt_s  = frame_cnt_r + 3'd1;
                        tx_payload_s = data_r[63:56];
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CMD: begin
                if (tx_done_s) begin
                    state_s   = ST_GAP;
                    gap_cnt_s = 1'b0;
                end else begin
                    state_s = ST_CMD;
                end
            end
            ST_GAP: begin
                // Ready is already up in the last gap cycle, so a waiting
                // command is taken on the edge that ends the gap.
                if (!gap_cnt_r) begin
                    gap_cnt_s = 1'b1;
                end else if (accept_s) begin
                    state_s      = ST_DATA;
                    gap_cnt_s    = 1'b0;
                    frame_cnt_s  = 3'd0;
                    tx_load_s    = 1'b1;
                    tx_payload_s = bus.B[31:24];
                end else begin
                    state_s   = ST_IDLE;
                    gap_cnt_s = 1'b0;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                frame_cnt_s = 3'd0;
                gap_cnt_s   = 1'b0;
            end
        endcase
        ready_s = (state_s == ST_IDLE) || ((state_s == ST_GAP) && gap_cnt_s);
        busy_s  = (state_s != ST_IDLE);
    end

    // Sequencer state, counters and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            frame_cnt_r <= 3'd0;
            gap_cnt_r   <= 1'b0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            frame_cnt_r <= frame_cnt_s;
            gap_cnt_r   <= gap_cnt_s;
            cmd_ready_r <= ready_s;
            busy_r      <= busy_s;
        end
    end

    // Command capture; the remaining data bytes shift up one byte per data frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r        <= 64'h0;
            cmd_payload_r <= 8'h00;
            omit_r        <= 1'b0;
        end else if (accept_s) begin
            data_r        <= {bus.B[23:0], bus.A, 8'h00};
            cmd_payload_r <= {1'b0, eff_op_s, crc_s};
            omit_r        <= bus.err_flags[0];
        end else if (tx_load_s && (state_r == ST_DATA)) begin
            data_r <= {data_r[55:0], 8'h00};
        end else begin
            data_r <= data_r;
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.busy      = busy_r;
    assign bus.sin       = tx_sin_s;

endmodule
